// File: rtl/apb4_mst_pkg.sv
// Shared types and constants for the APB4 initiator (apb4_mst_xfer).
package apb4_mst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb4_mst_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_mst_xfer.sv
// APB4 initiator: one command in on a valid/ready channel, one response out.
// Optional access timeout is built only when APB4_MST_TMO_EN is defined.
module apb4_mst_xfer
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tmo_o,
  input  logic [TMO_WIDTH-1:0]    tmo_lim_i,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  apb4_mst_state_e           state_q, state_d;
  logic                      rdy_q, rdy_d;
  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic [2:0]                pprot_q, pprot_d;
  logic                      pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      tmo_q, tmo_d;
  logic                      accept;
  logic                      tmo_hit;

  assign accept = req_valid_i & rdy_q;

`ifdef APB4_MST_TMO_EN
  logic [TMO_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept) begin
      wait_cnt_d = '0;
    end else if (state_q == ACCESS && !pready_i && wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end

  // The cycle that would bring the count up to the limit is the last one waited.
  assign tmo_hit = (state_q == ACCESS) && !pready_i && (tmo_lim_i != '0) &&
                   (wait_cnt_d >= tmo_lim_i);
`else
  logic unused_tmo_lim;
  assign unused_tmo_lim = ^tmo_lim_i;
  assign tmo_hit        = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d  = req_addr_i;
          pprot_d  = req_prot_i;
          pwrite_d = req_write_i;
          pwdata_d = req_write_i ? req_wdata_i : '0;
          pstrb_d  = req_write_i ? req_strb_i  : '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      paddr_q  <= '0;
      pprot_q  <= PROT_DEFAULT;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      paddr_q  <= paddr_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_ready_o = rdy_q;
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = paddr_q;
  assign pprot_o     = pprot_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rsp_tmo_o   = tmo_q;

endmodule

// File: tb/tb_apb4_mst_xfer.sv
// Self-checking bench for apb4_mst_xfer: directed cases plus random transfers
// against a per-transaction reference model. Timeout cases depend on APB4_MST_TMO_EN.
module tb_apb4_mst_xfer;

`ifdef APB4_MST_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_rdata;
  logic [7:0]  tmo_lim;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  apb4_mst_xfer dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo), .tmo_lim_i(tmo_lim),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One complete transfer, entered and left on a negedge with the DUT idle.
  // waits = ACCESS cycles the slave holds pready low before completing.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int waits,
                         input logic serr, input logic [31:0] rdat, input int hold,
                         input logic keep_valid);
    logic        exp_tmo, exp_err;
    logic [31:0] exp_rdata, exp_wdata;
    logic [3:0]  exp_strb;
    logic [71:0] exp_bus;
    int          exp_acc, acc;
    exp_tmo   = TMO_EN && (tmo_lim != 8'd0) && (waits >= int'(tmo_lim));
    exp_acc   = exp_tmo ? int'(tmo_lim) : waits + 1;
    exp_err   = exp_tmo || serr;
    exp_rdata = (exp_tmo || wr) ? 32'd0 : rdat;
    exp_wdata = wr ? wdata : 32'd0;
    exp_strb  = wr ? strb : 4'd0;
    exp_bus   = {addr, wr, exp_wdata, exp_strb, prot};

    check("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb; req_prot = prot;
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    check("setup_sel_en", {psel, penable}, 2'b10);
    check("setup_ready", req_ready, 1'b0);
    check("setup_bus", {paddr, pwrite, pwdata, pstrb, pprot}, exp_bus);

    acc = 0;
    @(negedge clk);
    while (psel && acc < 300) begin
      check("access_en", penable, 1'b1);
      check("access_bus", {paddr, pwrite, pwdata, pstrb, pprot}, exp_bus);
      pready  = (acc == waits);
      pslverr = serr && (acc == waits);
      prdata  = (acc == waits) ? rdat : $urandom;
      acc++;
      @(negedge clk);
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    check("access_cycles", acc, exp_acc);

    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_fields", {rsp_rdata, rsp_err, rsp_tmo}, {exp_rdata, exp_err, exp_tmo});
      check("rsp_bus_idle", {psel, penable, req_ready}, 3'b000);
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("back_idle", {rsp_valid, req_ready}, 2'b01);
    check("addr_kept", paddr, addr);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
    tmo_lim = 8'd0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", {req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, paddr, pprot,
                         psel, penable, pwrite, pwdata, pstrb}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    // Zero-wait write, then read with 3 wait states.
    do_xfer(1'b1, 32'h4, 32'h1234_5678, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    do_xfer(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 1'b0, 32'hA5A5_0001, 0, 1'b0);
    // Slave error with valid held: no second accept until the response is taken.
    do_xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'd1, 1, 1'b1, 32'h0BAD_0BAD, 3, 1'b1);
    // Timeout at the limit, and completion in the timeout cycle itself.
    tmo_lim = 8'd5;
    do_xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'd0, 8, 1'b0, 32'h1111_2222, 0, 1'b0);
    do_xfer(1'b1, 32'h34, 32'hCAFE_F00D, 4'h3, 3'd5, 4, 1'b0, 32'h3333_4444, 0, 1'b0);
    tmo_lim = 8'd1;
    do_xfer(1'b0, 32'h38, 32'h0, 4'h0, 3'd0, 2, 1'b0, 32'h5555_6666, 0, 1'b0);
    tmo_lim = 8'd0;
    // Response back-pressure for 10 cycles with a pending command.
    do_xfer(1'b1, 32'h40, 32'h0F0F_0F0F, 4'h5, 3'd7, 0, 1'b0, 32'h0, 10, 1'b1);
    do_xfer(1'b0, 32'h44, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h7777_8888, 0, 1'b0);

    // Reset in the middle of ACCESS.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_prot = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_access", {psel, penable}, 2'b11);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_access", {psel, penable, rsp_valid, req_ready, paddr}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_xfer(1'b1, 32'h60, 32'h89AB_CDEF, 4'hC, 3'd0, 0, 1'b0, 32'h0, 0, 1'b0);

    // Random transfers.
    for (int n = 0; n < 40; n++) begin
      tmo_lim = 8'($urandom_range(0, 7));
      do_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 6)), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
